park_gate_ctrl: RTL and testbench
=================================

// Module: park_gate_ctrl
// PURPOSE
//  Gate-side command initiator for the parking lot. It drives the 2-bit command bus consumed by the slot manager.
//  Per admitted car it issues exactly one ENTRY cycle; per departing car it issues exactly one EXIT cycle.
//  It times the entry and exit barriers, refuses entry when the lot is full, and reports ALARM on an access-code lockout.
// PARAMETERS
//  NSLOTS       4      number of slots; width of the slots input
//  GATE_CYCLES  8      cycles a barrier stays open after a command; must be >= 1
//  CODE_W       4      access-code width
//  ACCESS_CODE  4'hA   code that grants entry (used only with PARK_ALARM_EN)
//  MAX_TRIES    3      consecutive bad codes that trigger lockout
//  LOCK_CYCLES  16     lockout duration in cycles
// PORTS
//  clk            in   1                       clock
//  rst            in   1                       reset; asynchronous, active-high
//  entry_req      in   1                       car at entry gate (level)
//  exit_req       in   1                       car at exit gate (level)
//  code_valid     in   1                       code_in valid this cycle
//  code_in        in   CODE_W                  access code presented at entry
//  slots          in   NSLOTS                  occupancy fed back from slot manager (1 = occupied)
//  cmd            out  2                       IDLE=00 ENTRY=01 EXIT=10 ALARM=11
//  gate_in_open   out  1                       entry barrier open
//  gate_out_open  out  1                       exit barrier open
//  full           out  1                       &slots
//  free_count     out  $clog2(NSLOTS+1)        NSLOTS - popcount(slots)
//  reject         out  1                       1-cycle pulse: entry refused (full or bad code)
//  alarm          out  1                       high in lockout
// BEHAVIOUR
//  - Reset values: FSM=S_IDLE, cmd=00, gate_in_open=0, gate_out_open=0, reject=0, alarm=0, try counter=0, timer=0.
//  - full and free_count are combinational from slots; all other outputs are registered.
//  - States:
//      S_IDLE  -> S_ADMIT   (accepted entry)
//      S_IDLE  -> S_RELEASE (exit)
//      S_ADMIT -> S_GATE_IN  (1 cycle, cmd=ENTRY)
//      S_RELEASE -> S_GATE_OUT (1 cycle, cmd=EXIT)
//      S_GATE_IN / S_GATE_OUT -> S_IDLE after GATE_CYCLES cycles
//      S_LOCK -> S_IDLE after LOCK_CYCLES cycles
//  - Requests are sampled only in S_IDLE; requests arriving in any other state are ignored (no queueing).
//  - Latency: request sampled at edge N -> cmd=ENTRY/EXIT for exactly the cycle after edge N.
//    The barrier output is high for the GATE_CYCLES cycles that follow.
//  - cmd is 00 in every state except S_ADMIT (01), S_RELEASE (10) and S_LOCK (11).
//  - Priority in S_IDLE: exit_req && |slots wins over entry (frees space first).
//    exit_req with slots==0 is ignored (no EXIT issued).
//  - Entry with full=1: no ENTRY issued, reject pulses 1 cycle, FSM stays S_IDLE.
//    The try counter is unchanged.
//  - The gate phase lasts >= 1 cycle, so slots has settled from the slot manager before the next S_IDLE sample.
//  - Reset mid-operation: immediate return to reset values; an ENTRY/EXIT in flight is dropped.
// CONFIGURATION
//  - PARK_ALARM_EN defined:
//      - Entry requires entry_req && code_valid && code_in==ACCESS_CODE in the same cycle.
//      - entry_req && code_valid && mismatch: reject pulse and try counter +1.
//        When the counter reaches MAX_TRIES, go to S_LOCK (cmd=ALARM, alarm=1) for LOCK_CYCLES, then S_IDLE with counter=0.
//      - A successful entry clears the counter.
//      - entry_req without code_valid is ignored.
//      - The full check takes precedence over the code check.
//  - PARK_ALARM_EN undefined:
//      - entry_req alone admits; code_in and code_valid are ignored.
//      - S_LOCK is unreachable; alarm is tied 0 and cmd never equals 11.
// STRUCTURE
//  - Package park_pkg:
//      - cmd localparams CMD_IDLE/CMD_ENTRY/CMD_EXIT/CMD_ALARM, shared with the slot manager.
//      - FSM state typedef.
//  - Sub-module park_timer:
//      - loadable down-counter with done flag.
//      - One instance, reused for the gate hold time and for the lockout.
// TESTING
//  1. Empty lot, entry_req 1 cycle -> cmd=01 one cycle, gate_in_open 8 cycles, free_count 4->3, no reject.
//  2. slots=4'b1111, entry_req -> reject 1 cycle, cmd stays 00, gate_in_open 0, full=1.
//  3. slots=4'b0011, entry_req and exit_req same cycle -> cmd=10 (EXIT) first, gate_out_open 8 cycles; entry_req then re-sampled.
//  4. exit_req with slots=0 -> no command, no gate open.
//  5. PARK_ALARM_EN: three code_in=4'h3 attempts -> 3 rejects, then cmd=11/alarm=1 for 16 cycles, then IDLE;
//     a code of 4'hA then admits.
//  6. rst asserted during S_GATE_IN -> gate_in_open=0 and cmd=00 immediately; a new entry after release works.

Source files
------------

// File: rtl/park_pkg.sv
// Shared definitions for the parking-lot gate controller: command bus encoding
// (also decoded by the slot manager) and the controller FSM states.
package park_pkg;

   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_ENTRY = 2'b01;
   localparam logic [1:0] CMD_EXIT  = 2'b10;
   localparam logic [1:0] CMD_ALARM = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADMIT,
      S_RELEASE,
      S_GATE_IN,
      S_GATE_OUT,
      S_LOCK
   } state_t;

   // Bus value driven while the FSM sits in a given state.
   function automatic logic [1:0] cmd_of(input state_t s);
      case (s)
         S_ADMIT:   return CMD_ENTRY;
         S_RELEASE: return CMD_EXIT;
         S_LOCK:    return CMD_ALARM;
         default:   return CMD_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/park_timer.sv
// Loadable down-counter with a done flag; shared by the barrier hold time and
// the access-code lockout.
module park_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/park_gate_ctrl.sv
// Gate-side command initiator: issues ENTRY/EXIT commands, times the barriers.
// Optional access-code lockout is enabled by defining PARK_ALARM_EN.
module park_gate_ctrl
   import park_pkg::*;
#(
   parameter int                NSLOTS      = 4,
   parameter int                GATE_CYCLES = 8,
   parameter int                CODE_W      = 4,
   parameter logic [CODE_W-1:0] ACCESS_CODE = 'hA,
   parameter int                MAX_TRIES   = 3,
   parameter int                LOCK_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         entry_req,
   input  logic                         exit_req,
   input  logic                         code_valid,
   input  logic [CODE_W-1:0]            code_in,
   input  logic [NSLOTS-1:0]            slots,
   output logic [1:0]                   cmd,
   output logic                         gate_in_open,
   output logic                         gate_out_open,
   output logic                         full,
   output logic [$clog2(NSLOTS+1)-1:0]  free_count,
   output logic                         reject,
   output logic                         alarm
);

   localparam int FREE_W = $clog2(NSLOTS + 1);
   localparam int TMAX   = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
   localparam int TW     = $clog2(TMAX + 1);

   state_t          state, state_d;
   logic            reject_d;
   logic            tmr_load;
   logic [TW-1:0]   tmr_val;
   logic            tmr_done;
   logic            attempt;
   logic            code_ok;
   logic [FREE_W-1:0] occupied;

   assign full = &slots;

   always_comb begin
      occupied = '0;
      for (int i = 0; i < NSLOTS; i++) begin
         occupied = occupied + FREE_W'(slots[i]);
      end
   end

   assign free_count = FREE_W'(NSLOTS) - occupied;

`ifdef PARK_ALARM_EN
   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   logic [TRY_W-1:0] tries, tries_d;

   assign attempt = entry_req && code_valid;
   assign code_ok = (code_in == ACCESS_CODE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tries <= '0;
      else     tries <= tries_d;
   end
`else
   logic unused_cfg;

   assign attempt    = entry_req;
   assign code_ok    = 1'b1;
   assign unused_cfg = ^{code_valid, code_in, ACCESS_CODE, MAX_TRIES};
`endif

   park_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d  = state;
      reject_d = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
`ifdef PARK_ALARM_EN
      tries_d  = tries;
`endif
      case (state)
         S_IDLE: begin
            // Releasing a car frees space, so exit wins over entry.
            if (exit_req && |slots) begin
               state_d = S_RELEASE;
            end else if (attempt) begin
               if (full) begin
                  reject_d = 1'b1;
               end else if (!code_ok) begin
                  reject_d = 1'b1;
`ifdef PARK_ALARM_EN
                  tries_d = tries + 1'b1;
                  if (tries_d == TRY_W'(MAX_TRIES)) begin
                     state_d  = S_LOCK;
                     tries_d  = '0;
                     tmr_load = 1'b1;
                     tmr_val  = TW'(LOCK_CYCLES - 1);
                  end
`endif
               end else begin
                  state_d = S_ADMIT;
`ifdef PARK_ALARM_EN
                  tries_d = '0;
`endif
               end
            end
         end
         S_ADMIT: begin
            state_d  = S_GATE_IN;
            tmr_load = 1'b1;
            tmr_val  = TW'(GATE_CYCLES - 1);
         end
         S_RELEASE: begin
            state_d  = S_GATE_OUT;
            tmr_load = 1'b1;
            tmr_val  = TW'(GATE_CYCLES - 1);
         end
         S_GATE_IN, S_GATE_OUT, S_LOCK: begin
            if (tmr_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         cmd           <= CMD_IDLE;
         gate_in_open  <= 1'b0;
         gate_out_open <= 1'b0;
         reject        <= 1'b0;
      end else begin
         state         <= state_d;
         cmd           <= cmd_of(state_d);
         gate_in_open  <= (state_d == S_GATE_IN);
         gate_out_open <= (state_d == S_GATE_OUT);
         reject        <= reject_d;
      end
   end

`ifdef PARK_ALARM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) alarm <= 1'b0;
      else     alarm <= (state_d == S_LOCK);
   end
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Self-checking bench for park_gate_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an event model.
module tb_park_gate_ctrl;

   localparam int         NSLOTS = 4;
   localparam int         G      = 8;
   localparam int         L      = 16;
   localparam int         MAXT   = 3;
   localparam logic [3:0] CODE   = 4'hA;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic       code_valid = 1'b0;
   logic [3:0] code_in = '0;
   logic [3:0] slots = '0;
   logic [1:0] cmd;
   logic       gate_in_open, gate_out_open, full, reject, alarm;
   logic [2:0] free_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   park_gate_ctrl #(
      .NSLOTS(NSLOTS), .GATE_CYCLES(G), .CODE_W(4), .ACCESS_CODE(CODE),
      .MAX_TRIES(MAXT), .LOCK_CYCLES(L)
   ) dut (
      .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
      .code_valid(code_valid), .code_in(code_in), .slots(slots), .cmd(cmd),
      .gate_in_open(gate_in_open), .gate_out_open(gate_out_open), .full(full),
      .free_count(free_count), .reject(reject), .alarm(alarm)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Event model: at most one command episode in flight, described by its
   // kind and the cycle it was accepted; outputs follow by cycle arithmetic.
   typedef enum {EV_NONE, EV_ENTRY, EV_EXIT, EV_LOCK} ev_t;
   ev_t    ev = EV_NONE;
   longint ev_k = -100;
   longint rej_k = -100;
   longint next_s = 0;
   longint cyc = -1;
   int     tries = 0;

   always @(posedge clk) begin
      logic       attempt, code_match;
      logic [1:0] e_cmd;
      cyc++;
`ifdef PARK_ALARM_EN
      attempt    = entry_req && code_valid;
      code_match = (code_in == CODE);
`else
      attempt    = entry_req;
      code_match = 1'b1;
`endif
      if (rst) begin
         ev = EV_NONE; rej_k = -100; tries = 0; next_s = cyc + 1;
      end else if (cyc >= next_s) begin
         next_s = cyc + 1;
         if (exit_req && slots != 0) begin
            ev = EV_EXIT; ev_k = cyc; next_s = cyc + G + 2;
         end else if (attempt) begin
            if (slots == 4'hF) begin
               rej_k = cyc;
            end else if (!code_match) begin
               rej_k = cyc;
               tries++;
               if (tries == MAXT) begin
                  ev = EV_LOCK; ev_k = cyc; tries = 0; next_s = cyc + L + 1;
               end
            end else begin
               tries = 0; ev = EV_ENTRY; ev_k = cyc; next_s = cyc + G + 2;
            end
         end
      end
      #1;
      e_cmd = 2'b00;
      if (ev == EV_ENTRY && cyc == ev_k) e_cmd = 2'b01;
      if (ev == EV_EXIT  && cyc == ev_k) e_cmd = 2'b10;
      if (ev == EV_LOCK  && cyc >= ev_k && cyc < ev_k + L) e_cmd = 2'b11;
      check("cmd", cmd, e_cmd);
      check("gate_in_open", gate_in_open, ev == EV_ENTRY && cyc > ev_k && cyc <= ev_k + G);
      check("gate_out_open", gate_out_open, ev == EV_EXIT && cyc > ev_k && cyc <= ev_k + G);
      check("alarm", alarm, e_cmd == 2'b11);
      check("reject", reject, rej_k == cyc);
      check("full", full, slots == 4'hF);
      check("free_count", free_count, NSLOTS - $countones(slots));
   end

   initial begin
      #1 rst = 1'b1;
      #1;
      check("reset_cmd", cmd, 0);
      check("reset_gate_in", gate_in_open, 0);
      check("reset_gate_out", gate_out_open, 0);
      check("reset_reject", reject, 0);
      check("reset_alarm", alarm, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      code_valid = 1'b1;
      code_in = CODE;

      // 1: empty lot, one entry
      slots = 4'b0000; entry_req = 1'b1;
      tick();
      entry_req = 1'b0;
      check("t1_cmd", cmd, 1);
      check("t1_reject", reject, 0);
      check("t1_gate_early", gate_in_open, 0);
      check("t1_free_before", free_count, 4);
      slots = 4'b0001;
      for (int i = 0; i < G; i++) begin
         tick();
         check("t1_gate_in", gate_in_open, 1);
         check("t1_cmd_hold", cmd, 0);
      end
      check("t1_free_after", free_count, 3);
      tick();
      check("t1_gate_closed", gate_in_open, 0);

      // 2: full lot refuses entry
      slots = 4'hF; entry_req = 1'b1;
      tick();
      entry_req = 1'b0;
      check("t2_reject", reject, 1);
      check("t2_cmd", cmd, 0);
      check("t2_gate", gate_in_open, 0);
      check("t2_full", full, 1);
      tick();
      check("t2_reject_pulse", reject, 0);

      // 3: exit beats simultaneous entry; entry re-sampled afterwards
      slots = 4'b0011; entry_req = 1'b1; exit_req = 1'b1;
      tick();
      exit_req = 1'b0;
      check("t3_cmd_exit", cmd, 2);
      for (int i = 0; i < G; i++) begin
         tick();
         check("t3_gate_out", gate_out_open, 1);
      end
      tick();
      check("t3_gate_out_closed", gate_out_open, 0);
      check("t3_idle_cmd", cmd, 0);
      tick();
      check("t3_entry_resample", cmd, 1);
      entry_req = 1'b0;
      repeat (G + 1) tick();

      // 4: exit from an empty lot is ignored
      slots = 4'b0000; exit_req = 1'b1;
      tick();
      check("t4_cmd", cmd, 0);
      check("t4_gate", gate_out_open, 0);
      tick();
      check("t4_gate_later", gate_out_open, 0);
      exit_req = 1'b0;

`ifdef PARK_ALARM_EN
      // 5: three bad codes lock the gate out, then a good code admits
      code_in = 4'h3; entry_req = 1'b1;
      for (int i = 0; i < MAXT; i++) begin
         tick();
         check("t5_reject", reject, 1);
      end
      entry_req = 1'b0;
      check("t5_alarm", alarm, 1);
      check("t5_cmd_alarm", cmd, 3);
      for (int i = 1; i < L; i++) begin
         tick();
         check("t5_alarm_hold", alarm, 1);
      end
      tick();
      check("t5_alarm_clear", alarm, 0);
      check("t5_cmd_idle", cmd, 0);
      code_in = CODE; entry_req = 1'b1;
      tick();
      entry_req = 1'b0;
      check("t5_admit", cmd, 1);
      repeat (G + 1) tick();
`endif

      // 6: reset during the entry gate phase
      entry_req = 1'b1;
      tick();
      entry_req = 1'b0;
      check("t6_cmd", cmd, 1);
      tick();
      tick();
      check("t6_gate_open", gate_in_open, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_gate_reset", gate_in_open, 0);
      check("t6_cmd_reset", cmd, 0);
      tick();
      rst = 1'b0; entry_req = 1'b1;
      tick();
      entry_req = 1'b0;
      check("t6_entry_after", cmd, 1);
      repeat (G + 1) tick();

      // Randomized traffic, checked by the model every cycle
      for (int n = 0; n < 2000; n++) begin
         rst        = ($urandom_range(0, 299) == 0);
         entry_req  = ($urandom_range(0, 9) < 4);
         exit_req   = ($urandom_range(0, 9) < 3);
         slots      = 4'($urandom);
         code_valid = 1'($urandom_range(0, 1));
         code_in    = ($urandom_range(0, 2) == 0) ? CODE : 4'($urandom);
         @(negedge clk);
      end
      rst = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
